// File: rtl/round_timer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : round_timer_if                                                  |
// | Purpose  : Control and display bundle of the round countdown timer.        |
// |            master = game controller / upstream side (drives the controls), |
// |            slave  = round_timer (drives the display digits and flags).     |
// | Signals  : tick, start, pause, load, load_val[6:0]   master -> slave       |
// |            sec_tens[3:0], sec_ones[3:0], running,                          |
// |            done, expired, warn                      slave  -> master       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface round_timer_if;
   logic       tick;
   logic       start;
   logic       pause;
   logic       load;
   logic [6:0] load_val;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       done;
   logic       expired;
   logic       warn;

   modport master (
      output tick, start, pause, load, load_val,
      input  sec_tens, sec_ones, running, done, expired, warn
   );

   modport slave (
      input  tick, start, pause, load, load_val,
      output sec_tens, sec_ones, running, done, expired, warn
   );
endinterface
`default_nettype wire

// File: rtl/round_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : round_timer                                                     |
// | Purpose  : Counts upstream tick pulses into seconds and runs a loadable    |
// |            two-digit BCD countdown (IDLE / RUN / PAUSED / DONE) for a game |
// |            round. All outputs are registered.                              |
// | Ports    : clk          system clock                                       |
// |            rst          asynchronous, active-low reset                     |
// |            bus (slave)  tick/start/pause/load/load_val in,                 |
// |                         sec_tens/sec_ones/running/done/expired/warn out    |
// | Params   : TICKS_PER_SEC (2..16) ticks per displayed second                 |
// |            START_SEC     (0..99) countdown value after reset               |
// | Macro    : ROUND_TIMER_WARN_EN - builds the registered low-time warn flag;  |
// |            when undefined warn is tied to 0.                               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module round_timer #(
   parameter int TICKS_PER_SEC = 10,
   parameter int START_SEC     = 30
) (
   input  wire logic     clk,
   input  wire logic     rst,
   round_timer_if.slave  bus
);

   localparam logic [1:0] c_st_idle   = 2'd0;
   localparam logic [1:0] c_st_run    = 2'd1;
   localparam logic [1:0] c_st_paused = 2'd2;
   localparam logic [1:0] c_st_done   = 2'd3;

   localparam logic [3:0] c_start_tens = 4'(START_SEC / 10);
   localparam logic [3:0] c_start_ones = 4'(START_SEC % 10);
   localparam logic [3:0] c_sub_last   = 4'(TICKS_PER_SEC - 1);

   logic [1:0] r_state, w_state_nxt;
   logic [3:0] r_tens,  w_tens_nxt;
   logic [3:0] r_ones,  w_ones_nxt;
   logic [3:0] r_sub,   w_sub_nxt;
   logic       r_running, w_running_nxt;
   logic       r_done,    w_done_nxt;
   logic       r_expired, w_expired_nxt;

   // Load value: clamp to 99, then split into BCD digits.
   logic [6:0] w_load_clamped;
   logic [3:0] w_load_tens;
   logic [3:0] w_load_ones;

   assign w_load_clamped = (bus.load_val > 7'd99) ? 7'd99 : bus.load_val;
   assign w_load_tens    = 4'(w_load_clamped / 7'd10);
   assign w_load_ones    = 4'(w_load_clamped % 7'd10);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= c_st_idle;
         r_tens    <= c_start_tens;
         r_ones    <= c_start_ones;
         r_sub     <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tens    <= w_tens_nxt;
         r_ones    <= w_ones_nxt;
         r_sub     <= w_sub_nxt;
         r_running <= w_running_nxt;
         r_done    <= w_done_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   // ---------------------------------------------------------- next-state comb
   // Priority: load > start > pause > tick. In RUN, start has no meaning, so
   // a raised pause always wins over a coincident tick.
   always_comb begin
      w_state_nxt = r_state;
      w_tens_nxt  = r_tens;
      w_ones_nxt  = r_ones;
      w_sub_nxt   = r_sub;

      if (bus.load) begin
         w_state_nxt = c_st_idle;
         w_sub_nxt   = 4'd0;
         w_tens_nxt  = w_load_tens;
         w_ones_nxt  = w_load_ones;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (bus.start) begin
                  w_state_nxt = ((r_tens == 4'd0) && (r_ones == 4'd0)) ? c_st_done
                                                                       : c_st_run;
               end
            end
            c_st_run: begin
               if (bus.pause) begin
                  w_state_nxt = c_st_paused;
               end else if (bus.tick) begin
                  if (r_sub == c_sub_last) begin
                     w_sub_nxt = 4'd0;
                     if (r_ones == 4'd0) begin
                        w_ones_nxt = 4'd9;
                        // Tens never underflows; 00 leaves RUN before it could.
                        if (r_tens != 4'd0) begin
                           w_tens_nxt = r_tens - 4'd1;
                        end
                     end else begin
                        w_ones_nxt = r_ones - 4'd1;
                     end
                     // Decrement from 01 reaches 00: expire in the same clock.
                     if ((r_tens == 4'd0) && (r_ones == 4'd1)) begin
                        w_state_nxt = c_st_done;
                     end
                  end else begin
                     w_sub_nxt = r_sub + 4'd1;
                  end
               end
            end
            c_st_paused: begin
               if (!bus.pause) begin
                  w_state_nxt = c_st_run;
               end
            end
            default: begin
               // DONE: only load or reset leaves.
            end
         endcase
      end
   end

   // -------------------------------------------------------------- output comb
   // Flags are computed from the next state and registered, so they line up
   // with the digits they describe.
   always_comb begin
      w_running_nxt = (w_state_nxt == c_st_run);
      w_done_nxt    = (w_state_nxt == c_st_done);
      w_expired_nxt = (w_state_nxt == c_st_done) && (r_state != c_st_done);
   end

`ifdef ROUND_TIMER_WARN_EN
   logic r_warn;
   logic w_warn_nxt;

   always_comb begin
      w_warn_nxt = ((w_state_nxt == c_st_run) || (w_state_nxt == c_st_paused))
                   && (w_tens_nxt == 4'd0) && (w_ones_nxt <= 4'd5);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_warn <= 1'b0;
      end else begin
         r_warn <= w_warn_nxt;
      end
   end

   assign bus.warn = r_warn;
`else
   assign bus.warn = 1'b0;
`endif

   assign bus.sec_tens = r_tens;
   assign bus.sec_ones = r_ones;
   assign bus.running  = r_running;
   assign bus.done     = r_done;
   assign bus.expired  = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_round_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_round_timer                                                  |
// | Purpose  : Directed, self-checking bench for round_timer (default params). |
// |            Each step pushes its expected display/flags onto a scoreboard   |
// |            queue, clocks the DUT and pops/compares after the edge.         |
// | Macro    : ROUND_TIMER_WARN_EN - when defined, warn is expected to follow  |
// |            the low-time rule; otherwise it is expected to stay 0.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_round_timer;

`ifdef ROUND_TIMER_WARN_EN
   localparam logic c_warn_on = 1'b1;
`else
   localparam logic c_warn_on = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   round_timer_if bus ();

   round_timer #(
      .TICKS_PER_SEC (10),
      .START_SEC     (30)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [11:0] v;   // {tens, ones, running, done, expired, warn}
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Expected vector; live = state is RUN or PAUSED (warn only possible there).
   function automatic logic [11:0] ev(input logic [3:0] t, input logic [3:0] o,
                                      input logic run, input logic dn,
                                      input logic ex, input logic live);
      logic w;
      w = c_warn_on & live & (t == 4'd0) & (o <= 4'd5);
      return {t, o, run, dn, ex, w};
   endfunction

   task automatic pop_compare();
      exp_t        e;
      logic [11:0] obs;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL scoreboard_empty observed=none expected=entry");
         return;
      end
      e   = sb.pop_front();
      obs = {bus.sec_tens, bus.sec_ones, bus.running, bus.done, bus.expired, bus.warn};
      total++;
      assert (obs === e.v) else begin
         bad++;
         $error("FAIL %s observed=%03h expected=%03h (tens,ones,run,done,exp,warn)",
                e.tag, obs, e.v);
      end
   endtask

   task automatic check_now(input string tag, input logic [11:0] e);
      exp_t x;
      x.tag = tag;
      x.v   = e;
      sb.push_back(x);
      pop_compare();
   endtask

   // One clock with the given inputs applied, then compare.
   task automatic step(input logic tk, input logic st, input logic pa, input logic ld,
                       input logic [6:0] lv, input string tag, input logic [11:0] e);
      exp_t x;
      x.tag = tag;
      x.v   = e;
      sb.push_back(x);
      bus.tick     = tk;
      bus.start    = st;
      bus.pause    = pa;
      bus.load     = ld;
      bus.load_val = lv;
      @(posedge clk);
      #1;
      pop_compare();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
      bus.load = 1'b0; bus.load_val = 7'd0;

      // Reset and default value.
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_now("reset", ev(3, 0, 0, 0, 0, 0));
      rst = 1'b1;
      step(0, 0, 0, 0, 0, "idle",      ev(3, 0, 0, 0, 0, 0));
      step(1, 0, 0, 0, 0, "idle_tick", ev(3, 0, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0, "start",     ev(3, 0, 1, 0, 0, 1));
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "run_sub", ev(3, 0, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "run_29",    ev(2, 9, 1, 0, 0, 1));

      // Borrow from tens.
      step(0, 0, 0, 1, 7'd10, "load10",  ev(1, 0, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,     "start10", ev(1, 0, 1, 0, 0, 1));
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "b_sub", ev(1, 0, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "borrow",      ev(0, 9, 1, 0, 0, 1));

      // Expiry.
      step(0, 0, 0, 1, 7'd1, "load1",  ev(0, 1, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,    "start1", ev(0, 1, 1, 0, 0, 1));
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "e_sub", ev(0, 1, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "expire",      ev(0, 0, 0, 1, 1, 0));
      step(0, 0, 0, 0, 0, "expired_end", ev(0, 0, 0, 1, 0, 0));
      step(1, 1, 1, 0, 0, "done_hold",   ev(0, 0, 0, 1, 0, 0));

      // Pause at 2/0 with sub = 4.
      step(0, 0, 0, 1, 7'd21, "load21",  ev(2, 1, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,     "start21", ev(2, 1, 1, 0, 0, 1));
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "p_sub", ev(2, 1, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "p_20",        ev(2, 0, 1, 0, 0, 1));
      for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, "p_sub4", ev(2, 0, 1, 0, 0, 1));
      step(1, 0, 1, 0, 0, "pause_entry", ev(2, 0, 0, 0, 0, 1));
      for (int i = 0; i < 24; i++) step(1, 0, 1, 0, 0, "paused_hold", ev(2, 0, 0, 0, 0, 1));
      step(0, 1, 1, 0, 0, "paused_start", ev(2, 0, 0, 0, 0, 1));
      step(0, 0, 0, 0, 0, "resume",       ev(2, 0, 1, 0, 0, 1));
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "r_sub", ev(2, 0, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "resume_19",    ev(1, 9, 1, 0, 0, 1));

      // Clamp and zero start.
      step(0, 0, 0, 1, 7'd120, "clamp",     ev(9, 9, 0, 0, 0, 0));
      step(0, 0, 0, 1, 7'd0,   "load0",     ev(0, 0, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,      "zero_start", ev(0, 0, 0, 1, 1, 0));
      step(0, 0, 0, 0, 0,      "zero_end",  ev(0, 0, 0, 1, 0, 0));

      // Load beats coincident tick and start in RUN; sub restarts at 0.
      step(0, 0, 0, 1, 7'd15, "load15",  ev(1, 5, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,     "start15", ev(1, 5, 1, 0, 0, 1));
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "l_sub", ev(1, 5, 1, 0, 0, 1));
      step(1, 1, 0, 1, 7'd42, "reload_prio", ev(4, 2, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,     "start42",     ev(4, 2, 1, 0, 0, 1));
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "l2_sub", ev(4, 2, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0,     "reload_sub",  ev(4, 1, 1, 0, 0, 1));

      // Countdown from 7: warn window and expiry.
      step(0, 0, 0, 1, 7'd7, "load7",  ev(0, 7, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,    "start7", ev(0, 7, 1, 0, 0, 1));
      for (int s = 6; s >= 1; s--) begin
         for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "w_sub", ev(0, 4'(s + 1), 1, 0, 0, 1));
         step(1, 0, 0, 0, 0, "w_sec", ev(0, 4'(s), 1, 0, 0, 1));
      end
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "w_last", ev(0, 1, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "w_expire", ev(0, 0, 0, 1, 1, 0));
      step(0, 0, 0, 0, 0, "w_done",   ev(0, 0, 0, 1, 0, 0));

      // Asynchronous reset mid-countdown, no clock edge needed.
      step(0, 0, 0, 1, 7'd25, "load25",  ev(2, 5, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0,     "start25", ev(2, 5, 1, 0, 0, 1));
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "a_sub", ev(2, 5, 1, 0, 0, 1));
      #2;
      rst = 1'b0;
      #1;
      check_now("async_rst", ev(3, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_now("rst_held", ev(3, 0, 0, 0, 0, 0));
      rst = 1'b1;
      step(0, 1, 0, 0, 0, "post_rst_start", ev(3, 0, 1, 0, 0, 1));
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "pr_sub", ev(3, 0, 1, 0, 0, 1));
      step(1, 0, 0, 0, 0, "post_rst_29", ev(2, 9, 1, 0, 0, 1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
